hazard_sched_ctrl: RTL and testbench

//   Hazard and pipeline controller for the RSA pipelined CPU. It drives the stall, flush and

---
 rtl/hazard_sched_ctrl.sv | 162 ++++++++++++++++
 tb/tb_hazard_sched_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hazard_sched_ctrl.sv
// Stall/flush/forward control for the F/D/E/M segment registers, plus start/done sequencing of the multi-cycle unit.
// Hazard outputs are combinational. The state register updates on negedge clk, and the pipeline freezes while the unit is busy.
module hazard_sched_ctrl #(
  parameter int RA_W       = 4,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] ra1D,
  input  logic [RA_W-1:0] ra2D,
  input  logic [RA_W-1:0] ra1E,
  input  logic [RA_W-1:0] ra2E,
  input  logic [RA_W-1:0] wa3E,
  input  logic [RA_W-1:0] wa3M,
  input  logic [RA_W-1:0] wa3W,
  input  logic            RegWriteE,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic            MemtoRegE,
  input  logic            PCSrcE,
  input  logic            MultiCycleE,
  input  logic            mc_done,
  output logic            mc_start,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            FlushD,
  output logic            FlushE,
  output logic            FlushM,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            mc_timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic       lw_stall;
  logic       hz_stall_fd, hz_flush_d, hz_flush_e;
  logic [1:0] fwd_a, fwd_b;

  logic start, stall_fd, stall_e, flush_d, flush_e, flush_m;

  // Forwarding: the younger result in M takes priority over W.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (RegWriteM && (wa3M == ra1E))      fwd_a = 2'b10;
    else if (RegWriteW && (wa3W == ra1E)) fwd_a = 2'b01;
    if (RegWriteM && (wa3M == ra2E))      fwd_b = 2'b10;
    else if (RegWriteW && (wa3W == ra2E)) fwd_b = 2'b01;
  end

  assign lw_stall = MemtoRegE && RegWriteE && ((wa3E == ra1D) || (wa3E == ra2D));

  // A taken branch squashes the load-use bubble; the fetch stall would hold a wrong-path PC.
  always_comb begin
    hz_stall_fd = 1'b0;
    hz_flush_d  = 1'b0;
    hz_flush_e  = 1'b0;
    if (PCSrcE) begin
      hz_flush_d = 1'b1;
      hz_flush_e = 1'b1;
    end else if (lw_stall) begin
      hz_stall_fd = 1'b1;
      hz_flush_e  = 1'b1;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    start    = 1'b0;
    stall_fd = 1'b0;
    stall_e  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (MultiCycleE && !PCSrcE) begin
          // E is held for the unit, so no E bubble is inserted here.
          start    = 1'b1;
          stall_fd = 1'b1;
          stall_e  = 1'b1;
          flush_m  = 1'b1;
          state_d  = BUSY;
        end else begin
          stall_fd = hz_stall_fd;
          flush_d  = hz_flush_d;
          flush_e  = hz_flush_e;
        end
      end
      BUSY: begin
        stall_fd = 1'b1;
        stall_e  = 1'b1;
        flush_m  = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (mc_done)                state_d = DONE;
        else if (cnt_q == CNT_LAST) state_d = ABORT;
      end
      DONE: begin
        stall_fd = hz_stall_fd;
        flush_d  = hz_flush_d;
        flush_e  = hz_flush_e;
        cnt_d    = '0;
        state_d  = IDLE;
      end
      ABORT: begin
        stall_fd = hz_stall_fd;
        flush_d  = hz_flush_d;
        flush_e  = hz_flush_e;
        flush_m  = 1'b1;
        err_d    = 1'b1;
        cnt_d    = '0;
        state_d  = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // All outputs are held low for as long as reset is asserted.
  assign mc_start       = rst & start;
  assign StallF         = rst & stall_fd;
  assign StallD         = rst & stall_fd;
  assign StallE         = rst & stall_e;
  assign FlushD         = rst & flush_d;
  assign FlushE         = rst & flush_e;
  assign FlushM         = rst & flush_m;
  assign ForwardAE      = rst ? fwd_a : 2'b00;
  assign ForwardBE      = rst ? fwd_b : 2'b00;
  assign mc_timeout_err = rst & err_q;

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Directed-vector bench: stimulus pushes expected output words, and a posedge monitor pops and compares them.
module tb_hazard_sched_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ra1D, ra2D, ra1E, ra2E, wa3E, wa3M, wa3W;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCSrcE, MultiCycleE, mc_done;
  logic       mc_start, StallF, StallD, StallE, FlushD, FlushE, FlushM, mc_timeout_err;
  logic [1:0] ForwardAE, ForwardBE;

  // Output word: {mc_start, StallF, StallD, StallE, FlushD, FlushE, FlushM, FA[1:0], FB[1:0], err}
  localparam logic [11:0] ZERO  = 12'b0_000_000_00_00_0;
  localparam logic [11:0] START = 12'b1_111_001_00_00_0;
  localparam logic [11:0] BUSYV = 12'b0_111_001_00_00_0;
  localparam logic [11:0] LU    = 12'b0_110_010_00_00_0;
  localparam logic [11:0] BR    = 12'b0_000_110_00_00_0;
  localparam logic [11:0] ABRT  = 12'b0_000_001_00_00_0;
  localparam logic [11:0] ERR   = 12'b0_000_000_00_00_1;

  logic [11:0] dut_out;
  assign dut_out = {mc_start, StallF, StallD, StallE, FlushD, FlushE, FlushM,
                    ForwardAE, ForwardBE, mc_timeout_err};

  string       sb_nm[$];
  logic [11:0] sb_vec[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  hazard_sched_ctrl #(.RA_W(4), .MC_TIMEOUT(8), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .ra1D(ra1D), .ra2D(ra2D), .ra1E(ra1E), .ra2E(ra2E),
    .wa3E(wa3E), .wa3M(wa3M), .wa3W(wa3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE), .mc_done(mc_done),
    .mc_start(mc_start), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mc_timeout_err(mc_timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    string       nm;
    logic [11:0] want;
    if (sb_vec.size() != 0) begin
      nm   = sb_nm.pop_front();
      want = sb_vec.pop_front();
      n_chk++;
      if (dut_out === want) n_pass++;
      else $display("FAIL %s: got %b want %b", nm, dut_out, want);
    end
  end

  task automatic clr_in();
    ra1D = 4'd0; ra2D = 4'd0; ra1E = 4'd0; ra2E = 4'd0;
    wa3E = 4'd0; wa3M = 4'd0; wa3W = 4'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; PCSrcE = 1'b0; MultiCycleE = 1'b0; mc_done = 1'b0;
  endtask

  // Inputs change just after the state-update edge; the monitor samples at the following posedge.
  task automatic nxt();
    @(negedge clk);
    #1;
    clr_in();
  endtask

  task automatic exp(input string nm, input logic [11:0] v);
    sb_nm.push_back(nm);
    sb_vec.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    clr_in();
    nxt(); RegWriteM = 1; wa3M = 3; ra1E = 3; MultiCycleE = 1; PCSrcE = 1;
    exp("reset_outputs", ZERO);
    nxt(); rst = 1'b1; exp("post_reset_idle", ZERO);

    // Forwarding
    nxt(); RegWriteM = 1; wa3M = 3; RegWriteW = 1; wa3W = 3; ra1E = 3; ra2E = 5;
    exp("fwd_m_priority", 12'b0_000_000_10_00_0);
    nxt(); RegWriteW = 1; wa3W = 3; ra1E = 3; ra2E = 5;
    exp("fwd_w_only", 12'b0_000_000_01_00_0);
    nxt(); RegWriteM = 1; wa3M = 3; RegWriteW = 1; wa3W = 5; ra1E = 3; ra2E = 5;
    exp("fwd_a_m_b_w", 12'b0_000_000_10_01_0);
    nxt(); wa3M = 3; wa3W = 5; ra1E = 3; ra2E = 5;
    exp("fwd_no_regwrite", ZERO);

    // Load-use and branch
    nxt(); MemtoRegE = 1; RegWriteE = 1; wa3E = 2; ra2D = 2; ra1D = 7;
    exp("loaduse_stall", LU);
    nxt(); exp("loaduse_release", ZERO);
    nxt(); MemtoRegE = 1; RegWriteE = 1; wa3E = 2; ra2D = 2; ra1D = 7; PCSrcE = 1;
    exp("branch_over_loaduse", BR);
    nxt(); MemtoRegE = 1; wa3E = 2; ra2D = 2;
    exp("load_no_regwrite", ZERO);

    // Multi-cycle op with mc_done 5 cycles after mc_start; branch and load-use are masked in BUSY
    nxt(); MultiCycleE = 1; exp("mc_start", START);
    nxt(); MultiCycleE = 1; exp("mc_busy1", BUSYV);
    nxt(); MultiCycleE = 1; PCSrcE = 1; exp("mc_busy_branch_masked", BUSYV);
    nxt(); MultiCycleE = 1; MemtoRegE = 1; RegWriteE = 1; wa3E = 4; ra1D = 4;
    exp("mc_busy_loaduse_masked", BUSYV);
    nxt(); MultiCycleE = 1; exp("mc_busy4", BUSYV);
    nxt(); MultiCycleE = 1; mc_done = 1; exp("mc_busy5_done", BUSYV);
    nxt(); MultiCycleE = 1; exp("mc_done_state", ZERO);
    nxt(); exp("mc_back_idle", ZERO);

    // A taken branch in IDLE suppresses the start
    nxt(); MultiCycleE = 1; PCSrcE = 1; exp("branch_blocks_start", BR);

    // mc_done on the final counted BUSY cycle must still complete normally
    nxt(); MultiCycleE = 1; exp("edge_start", START);
    for (int i = 0; i < 8; i++) begin
      nxt(); MultiCycleE = 1; mc_done = (i == 7); exp("edge_busy", BUSYV);
    end
    nxt(); MultiCycleE = 1; exp("edge_done_no_err", ZERO);
    nxt(); exp("edge_idle_no_err", ZERO);

    // Back-to-back ops: the second starts immediately after DONE
    nxt(); MultiCycleE = 1; exp("b2b_start1", START);
    nxt(); MultiCycleE = 1; mc_done = 1; exp("b2b_busy1", BUSYV);
    nxt(); MultiCycleE = 1; exp("b2b_done1", ZERO);
    nxt(); MultiCycleE = 1; exp("b2b_start2", START);
    nxt(); MultiCycleE = 1; mc_done = 1; exp("b2b_busy2", BUSYV);
    nxt(); MultiCycleE = 1; exp("b2b_done2", ZERO);
    nxt(); exp("b2b_idle", ZERO);

    // Timeout: 8 BUSY cycles without mc_done
    nxt(); MultiCycleE = 1; exp("to_start", START);
    for (int i = 0; i < 8; i++) begin
      nxt(); MultiCycleE = 1; exp("to_busy", BUSYV);
    end
    nxt(); MultiCycleE = 1; exp("to_abort", ABRT);
    nxt(); exp("to_err_set", ERR);
    nxt(); RegWriteM = 1; wa3M = 6; ra2E = 6;
    exp("to_err_sticky", 12'b0_000_000_00_10_1);

    // Reset asserted on the third BUSY cycle
    nxt(); MultiCycleE = 1; exp("rst_start", START | ERR);
    nxt(); MultiCycleE = 1; exp("rst_busy1", BUSYV | ERR);
    nxt(); MultiCycleE = 1; exp("rst_busy2", BUSYV | ERR);
    nxt(); rst = 1'b0; MultiCycleE = 1; exp("rst_mid_busy", ZERO);
    nxt(); MultiCycleE = 1; RegWriteM = 1; wa3M = 3; ra1E = 3;
    exp("rst_held", ZERO);
    nxt(); rst = 1'b1; exp("rst_release_idle", ZERO);
    nxt(); mc_done = 1; exp("rst_stray_done", ZERO);
    nxt(); MultiCycleE = 1; exp("rst_fresh_start", START);
    nxt(); MultiCycleE = 1; mc_done = 1; exp("rst_fresh_busy", BUSYV);
    nxt(); MultiCycleE = 1; exp("rst_fresh_done", ZERO);
    nxt(); exp("final_idle", ZERO);

    for (int i = 0; i < 4 && sb_vec.size() != 0; i++) @(negedge clk);
    if (sb_vec.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending want 0", sb_vec.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
